switch_debounce: RTL and testbench

//   Input-conditioning stage between a raw board switch or button pin and the
//   LED/control logic in the top level. It:
//     - synchronises the asynchronous pin into the clk48 domain;
//     - debounces it with a stable-time counter;
//     - emits a clean level, single-cycle rise/fall pulses, and a toggle latch.

---
 rtl/sw_debounce_pkg.sv | 19 +
 rtl/switch_debounce_if.sv | 24 ++
 rtl/bit_sync.sv | 37 +++
 rtl/switch_debounce.sv | 81 ++++++++
 tb/tb_switch_debounce.sv | 137 +++++++++++++
 5 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debouncer: debounce length and
// counter width derived from the clock rate and required stable time.
package sw_debounce_pkg;

  // Number of consecutive clock edges a new level must persist; never below 1.
  function automatic int debounce_cycles(input int clk_hz, input int debounce_us);
    int n;
    n = (clk_hz / 1_000_000) * debounce_us;
    if (n < 1) begin
      n = 1;
    end
    return n;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// Switch-path signal bundle: raw pin in, conditioned level/pulse/toggle out.
interface switch_debounce_if;
  logic sw_raw;
  logic sw_level;
  logic sw_rise;
  logic sw_fall;
  logic sw_toggle;

  modport master (
    output sw_raw,
    input  sw_level,
    input  sw_rise,
    input  sw_fall,
    input  sw_toggle
  );

  modport slave (
    input  sw_raw,
    output sw_level,
    output sw_rise,
    output sw_fall,
    output sw_toggle
  );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous pin; SYNC_STAGES is expected
// in 2..4 and every stage resets to IDLE_LEVEL.
module bit_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_d[gi] = d;
      end else begin : g_rest
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Board switch conditioner: synchronise, debounce with a stable-time counter,
// and produce a clean level, one-cycle rise/fall pulses and a push-on/off toggle.
module switch_debounce
  import sw_debounce_pkg::*;
#(
  parameter int   CLK_HZ      = 48_000_000,
  parameter int   DEBOUNCE_US = 10_000,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic              clk48,
  input  logic              rst_n,
  switch_debounce_if.slave  sw
);

  localparam int N  = debounce_cycles(CLK_HZ, DEBOUNCE_US);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic          synced;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic          stable_q, stable_d;
  logic          rise_q,   rise_d;
  logic          fall_q,   fall_d;
  logic          toggle_q, toggle_d;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_LEVEL  (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk48),
    .rst_n (rst_n),
    .d     (sw.sw_raw),
    .q     (synced)
  );

  // Any return to the stable level before the count completes restarts it,
  // so short glitches never reach the outputs.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = synced;
      rise_d   = synced;
      fall_d   = ~synced;
      if (synced) begin
        toggle_d = ~toggle_q;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign sw.sw_level  = stable_q;
  assign sw.sw_rise   = rise_q;
  assign sw.sw_fall   = fall_q;
  assign sw.sw_toggle = toggle_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with N=4, two sync stages, idle level 0:
// a vector table for press/release/glitch/bounce plus reset-related sequences.
module tb_switch_debounce;

  localparam int NEVER = 99;

  typedef struct {
    logic raw;
    logic level;
    logic rise;
    logic fall;
    logic toggle;
  } vec_t;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  switch_debounce_if sw ();

  switch_debounce #(
    .CLK_HZ      (1_000_000),
    .DEBOUNCE_US (4),
    .SYNC_STAGES (2),
    .IDLE_LEVEL  (1'b0)
  ) dut (
    .clk48 (clk48),
    .rst_n (rst_n),
    .sw    (sw.slave)
  );

  always #5 clk48 = ~clk48;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic lvl, input logic r,
                           input logic f, input logic t);
    check({tag, ".level"},  sw.sw_level,  lvl);
    check({tag, ".rise"},   sw.sw_rise,   r);
    check({tag, ".fall"},   sw.sw_fall,   f);
    check({tag, ".toggle"}, sw.sw_toggle, t);
    check({tag, ".rise_and_fall"}, sw.sw_rise & sw.sw_fall, 1'b0);
  endtask

  // Segment of n cycles at one raw level; the debounced change (if any) is
  // expected on the check after cycle index `at` of the segment.
  task automatic add_seg(input logic raw, input int n, input logic lvl0,
                         input logic lvl1, input logic r, input logic f,
                         input logic t0, input logic t1, input int at);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v.raw    = raw;
      v.level  = (j < at) ? lvl0 : lvl1;
      v.rise   = (j == at) ? r : 1'b0;
      v.fall   = (j == at) ? f : 1'b0;
      v.toggle = (j < at) ? t0 : t1;
      vecs.push_back(v);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  initial begin
    sw.sw_raw = 1'b0;
    rst_n     = 1'b0;

    // Reset state, then idle with the pin low.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_all($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0);
      $display("idle cycle %0d level=%b", i, sw.sw_level);
    end

    // Two clean press/release cycles: change lands 5 edges after the raw step.
    add_seg(1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    add_seg(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5);
    add_seg(1'b1, 10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5);
    add_seg(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    // Three-cycle glitch: nothing changes.
    add_seg(1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER);
    add_seg(1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER);
    // Bounce 1x3, 0x2, then steady high; one rise after the final step.
    add_seg(1'b1, 3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER);
    add_seg(1'b0, 2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NEVER);
    add_seg(1'b1, 13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    add_seg(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5);

    foreach (vecs[i]) begin
      sw.sw_raw = vecs[i].raw;
      tick();
      check_all($sformatf("vec[%0d]", i), vecs[i].level, vecs[i].rise,
                vecs[i].fall, vecs[i].toggle);
      $display("vec %0d raw=%b level=%b rise=%b fall=%b toggle=%b", i,
               vecs[i].raw, sw.sw_level, sw.sw_rise, sw.sw_fall, sw.sw_toggle);
    end

    // Reset while the counter is at 2 with the pin high (toggle is 1 here).
    sw.sw_raw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("prereset[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_all("inreset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check_all($sformatf("postreset[%0d]", i), (i >= 6) ? 1'b1 : 1'b0,
                (i == 6) ? 1'b1 : 1'b0, 1'b0, (i >= 6) ? 1'b1 : 1'b0);
      $display("post-reset edge %0d level=%b rise=%b", i, sw.sw_level, sw.sw_rise);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
